// File: rtl/fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_pkg                                                                    |
// | Shared types and the dequantise/saturate helper for fir_complex_decim.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fir_pkg;

  typedef enum logic [1:0] {
    SHIFT  = 2'd0,
    MAC    = 2'd1,
    QUANT  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  localparam int c_CPLX_WIDTH = 32;
  localparam int c_SAT_WIDTH  = 128;

  typedef struct packed {
    logic signed [c_CPLX_WIDTH-1:0] i;
    logic signed [c_CPLX_WIDTH-1:0] q;
  } cplx_t;

  // Divide by 2^frac_bits rounding toward zero (bias negatives before the
  // arithmetic shift), then clamp to the signed data_width range.
  function automatic logic signed [c_SAT_WIDTH-1:0] sat_trunc(
    input logic signed [c_SAT_WIDTH-1:0] acc,
    input int                            frac_bits,
    input int                            data_width
  );
    logic signed [c_SAT_WIDTH-1:0] bias;
    logic signed [c_SAT_WIDTH-1:0] quot;
    logic signed [c_SAT_WIDTH-1:0] max_v;
    logic signed [c_SAT_WIDTH-1:0] min_v;
    bias  = (acc < 0) ? ((128'sd1 <<< frac_bits) - 128'sd1) : 128'sd0;
    quot  = (acc + bias) >>> frac_bits;
    max_v = (128'sd1 <<< (data_width - 1)) - 128'sd1;
    min_v = -(128'sd1 <<< (data_width - 1));
    if (quot > max_v) begin
      return max_v;
    end
    if (quot < min_v) begin
      return min_v;
    end
    return quot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_cmac_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_cmac_lane                                                              |
// | Combinational complex multiply of one tap: h * x.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fir_cmac_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic signed [DATA_WIDTH-1:0] x_re,
  input  logic signed [DATA_WIDTH-1:0] x_im,
  input  logic signed [DATA_WIDTH-1:0] h_re,
  input  logic signed [DATA_WIDTH-1:0] h_im,
  // One guard bit: a sum/difference of two full products can exceed 2*DATA_WIDTH.
  output logic signed [2*DATA_WIDTH:0] prod_re,
  output logic signed [2*DATA_WIDTH:0] prod_im
);

  localparam int c_FULL_W = 2 * DATA_WIDTH;

  logic signed [c_FULL_W-1:0] w_rr;
  logic signed [c_FULL_W-1:0] w_ii;
  logic signed [c_FULL_W-1:0] w_rq;
  logic signed [c_FULL_W-1:0] w_ir;

  assign w_rr = c_FULL_W'(h_re) * c_FULL_W'(x_re);
  assign w_ii = c_FULL_W'(h_im) * c_FULL_W'(x_im);
  assign w_rq = c_FULL_W'(h_re) * c_FULL_W'(x_im);
  assign w_ir = c_FULL_W'(h_im) * c_FULL_W'(x_re);

  assign prod_re = (c_FULL_W + 1)'(w_rr) - (c_FULL_W + 1)'(w_ii);
  assign prod_im = (c_FULL_W + 1)'(w_rq) + (c_FULL_W + 1)'(w_ir);

endmodule
`default_nettype wire

// File: rtl/fir_complex_decim.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_complex_decim                                                          |
// | Complex decimating FIR, loadable complex taps, LANES MACs per cycle.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fir_complex_decim
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAP_COUNT  = 20,
  parameter int LANES      = 2,
  parameter int DECIMATION = 1,
  parameter int FRAC_BITS  = 10,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(TAP_COUNT) + 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_empty,
  output logic                         in_rd_en,
  input  logic [DATA_WIDTH-1:0]        i_in,
  input  logic [DATA_WIDTH-1:0]        q_in,
  input  logic                         out_full,
  output logic                         out_wr_en,
  output logic [DATA_WIDTH-1:0]        i_out,
  output logic [DATA_WIDTH-1:0]        q_out,
  input  logic                         coef_wr_en,
  input  logic [$clog2(TAP_COUNT)-1:0] coef_addr,
  input  logic [DATA_WIDTH-1:0]        coef_re,
  input  logic [DATA_WIDTH-1:0]        coef_im,
  output logic                         coef_ready
);

  localparam int c_GROUPS = TAP_COUNT / LANES;
  localparam int c_ADDR_W = $clog2(TAP_COUNT);
  localparam int c_GRP_W  = (c_GROUPS > 1) ? $clog2(c_GROUPS) : 1;
  localparam int c_CNT_W  = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam int c_PROD_W = 2 * DATA_WIDTH + 1;

  state_t r_state;
  state_t w_state_next;

  logic [c_CNT_W-1:0]           r_shift_cnt;
  logic [c_GRP_W-1:0]           r_group;
  logic signed [DATA_WIDTH-1:0] r_xi [TAP_COUNT];
  logic signed [DATA_WIDTH-1:0] r_xq [TAP_COUNT];
  logic signed [DATA_WIDTH-1:0] r_hr [TAP_COUNT];
  logic signed [DATA_WIDTH-1:0] r_hi [TAP_COUNT];
  logic signed [ACC_WIDTH-1:0]  r_acc_i;
  logic signed [ACC_WIDTH-1:0]  r_acc_q;
  logic signed [ACC_WIDTH-1:0]  w_sum_i;
  logic signed [ACC_WIDTH-1:0]  w_sum_q;
  logic signed [c_PROD_W-1:0]   w_prod_re [LANES];
  logic signed [c_PROD_W-1:0]   w_prod_im [LANES];
  logic                         w_last_pop;
  logic                         w_last_group;
  logic                         w_addr_ok;
  logic                         w_coef_we;

  assign w_last_pop   = (r_shift_cnt == c_CNT_W'(DECIMATION - 1));
  assign w_last_group = (r_group == c_GRP_W'(c_GROUPS - 1));
  assign w_coef_we    = coef_wr_en && coef_ready && w_addr_ok;

  generate
    if ((1 << c_ADDR_W) > TAP_COUNT) begin : g_addr_chk
      assign w_addr_ok = ({1'b0, coef_addr} < (c_ADDR_W + 1)'(TAP_COUNT));
    end else begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end
  endgenerate

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [c_ADDR_W-1:0] w_tap;
      assign w_tap = c_ADDR_W'(int'(r_group) * LANES + l);
      fir_cmac_lane #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_lane (
        .x_re    (r_xi[w_tap]),
        .x_im    (r_xq[w_tap]),
        .h_re    (r_hr[w_tap]),
        .h_im    (r_hi[w_tap]),
        .prod_re (w_prod_re[l]),
        .prod_im (w_prod_im[l])
      );
    end
  endgenerate

  always_comb begin
    w_sum_i = r_acc_i;
    w_sum_q = r_acc_q;
    for (int l = 0; l < LANES; l++) begin
      w_sum_i = w_sum_i + ACC_WIDTH'(w_prod_re[l]);
      w_sum_q = w_sum_q + ACC_WIDTH'(w_prod_im[l]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= SHIFT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_rd_en     = 1'b0;
    out_wr_en    = 1'b0;
    coef_ready   = 1'b0;
    case (r_state)
      SHIFT: begin
        // Gated by reset so no pop strobe leaks out while the block is held.
        in_rd_en   = !in_empty && !reset;
        coef_ready = 1'b1;
        if (in_rd_en && w_last_pop) begin
          w_state_next = MAC;
        end
      end
      MAC: begin
        if (w_last_group) begin
          w_state_next = QUANT;
        end
      end
      QUANT: begin
        w_state_next = OUTPUT;
      end
      OUTPUT: begin
        coef_ready = 1'b1;
        if (!out_full) begin
          out_wr_en    = 1'b1;
          w_state_next = SHIFT;
        end
      end
      default: begin
        w_state_next = SHIFT;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift_cnt <= '0;
      r_group     <= '0;
      r_acc_i     <= '0;
      r_acc_q     <= '0;
      i_out       <= '0;
      q_out       <= '0;
      for (int k = 0; k < TAP_COUNT; k++) begin
        r_xi[k] <= '0;
        r_xq[k] <= '0;
        r_hr[k] <= '0;
        r_hi[k] <= '0;
      end
    end else begin
      if (w_coef_we) begin
        r_hr[coef_addr] <= coef_re;
        r_hi[coef_addr] <= coef_im;
      end
      if (in_rd_en) begin
        r_xi[0] <= i_in;
        r_xq[0] <= q_in;
        for (int k = 1; k < TAP_COUNT; k++) begin
          r_xi[k] <= r_xi[k-1];
          r_xq[k] <= r_xq[k-1];
        end
        if (w_last_pop) begin
          r_shift_cnt <= '0;
          r_group     <= '0;
          r_acc_i     <= '0;
          r_acc_q     <= '0;
        end else begin
          r_shift_cnt <= r_shift_cnt + 1'b1;
        end
      end
      if (r_state == MAC) begin
        r_acc_i <= w_sum_i;
        r_acc_q <= w_sum_q;
        r_group <= r_group + 1'b1;
      end
      if (r_state == QUANT) begin
        i_out <= DATA_WIDTH'(sat_trunc(c_SAT_WIDTH'(r_acc_i), FRAC_BITS, DATA_WIDTH));
        q_out <= DATA_WIDTH'(sat_trunc(c_SAT_WIDTH'(r_acc_q), FRAC_BITS, DATA_WIDTH));
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/fir_complex_decim.md
Name: fir_complex_decim

Overview:
Parametrised complex FIR filter with integer decimation, runtime-loadable complex coefficients and a configurable number of MAC lanes. It sits between two FIFOs in the demodulation chain, with a FIFO-read interface upstream and a FIFO-write interface downstream. It computes a full complex convolution with one wide accumulator per rail, dequantises once per output and saturates the result. It supersedes the fixed-coefficient, real-only-correct complex FIR.

Parameters:
- DATA_WIDTH, 32: sample and coefficient width; signed two's complement.
- TAP_COUNT, 20: number of taps; must be divisible by LANES.
- LANES, 2: complex MACs evaluated per cycle.
- DECIMATION, 1: input samples consumed per output sample; 1 or more.
- FRAC_BITS, 10: dequantisation shift applied to the accumulated sum.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(TAP_COUNT)+1: accumulator width.

Ports:
- clock, in, 1: clock.
- reset, in, 1: asynchronous, active-high.
- in_empty, in, 1: upstream FIFO empty.
- in_rd_en, out, 1: pop strobe to upstream FIFO.
- i_in, in, DATA_WIDTH: I sample; valid in the cycle in_rd_en=1.
- q_in, in, DATA_WIDTH: Q sample; valid in the cycle in_rd_en=1.
- out_full, in, 1: downstream FIFO full.
- out_wr_en, out, 1: push strobe to downstream FIFO.
- i_out, out, DATA_WIDTH: filtered I; valid when out_wr_en=1.
- q_out, out, DATA_WIDTH: filtered Q; valid when out_wr_en=1.
- coef_wr_en, in, 1: coefficient write strobe.
- coef_addr, in, $clog2(TAP_COUNT): tap index.
- coef_re, in, DATA_WIDTH: real part of coefficient h[coef_addr].
- coef_im, in, DATA_WIDTH: imaginary part of coefficient h[coef_addr].
- coef_ready, out, 1: high when a coefficient write will be accepted.

Behaviour:
- Reset: in_rd_en=0, out_wr_en=0, i_out=0, q_out=0. Delay lines, coefficients, accumulators and counters are cleared to 0. State goes to SHIFT. Reset mid-MAC abandons the partial output; no write is issued.
- SHIFT:
  - in_rd_en = !in_empty (combinational).
  - On each pop: x[0] <= {i_in, q_in} and x[k] <= x[k-1]; shift counter increments.
  - On the DECIMATION-th pop: shift counter clears, both accumulators clear, lane counter goes to 0, next state is MAC.
- MAC: one cycle per group, TAP_COUNT/LANES cycles total. Group g covers taps k = g*LANES .. g*LANES+LANES-1.
  - acc_i += sum(hr[k]*xi[k] - hh[k]*xq[k])
  - acc_q += sum(hr[k]*xq[k] + hh[k]*xi[k])
  - Products are signed full-width; sign-extend to ACC_WIDTH before adding.
  - After the last group, next state is QUANT.
- QUANT, 1 cycle:
  - res = acc / 2^FRAC_BITS, truncated toward zero (not an arithmetic shift; matters for negative values).
  - Saturate res to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Register res into i_out and q_out; next state is OUTPUT.
- OUTPUT:
  - While out_full=1, hold the outputs with out_wr_en=0.
  - When out_full=0, out_wr_en=1 for exactly one cycle, then return to SHIFT.
- No input is popped outside SHIFT; upstream back-pressure is inherent.
- Latency, last pop to out_wr_en with out_full=0: TAP_COUNT/LANES + 2 cycles.
- Coefficients:
  - coef_ready=1 in SHIFT and OUTPUT, 0 in MAC and QUANT.
  - A write with coef_ready=0 is dropped, not queued.
  - A write with coef_addr >= TAP_COUNT is ignored.
  - A write and a pop in the same cycle are both performed; the new coefficient applies from the next MAC.
- Throughput: one output per max(DECIMATION, 1) + TAP_COUNT/LANES + 2 cycles at best.

Decomposition:
- Package fir_pkg: state enum {SHIFT, MAC, QUANT, OUTPUT}; typedef cplx_t {i, q} at DATA_WIDTH; sat_trunc() function for the divide-truncate-saturate step.
- One sub-module, fir_cmac_lane: combinational complex multiply of one tap, returning (re, im) at 2*DATA_WIDTH. Instantiate LANES copies in a generate loop. The top level holds the FSM, delay line, coefficient RAM and accumulators.

Test Plan:
- Impulse response: DECIMATION=1, TAP_COUNT=4, LANES=2, FRAC_BITS=0, h={1+0j, 2+0j, 3+1j, 4-1j}. Feed (1,0) then three (0,0). Required outputs: (1,0), (2,0), (3,1), (4,-1).
- Complex correctness: h[0]=2+3j, other taps 0, FRAC_BITS=0, input (5,7). Required output (-11, 29).
- Decimation: DECIMATION=4, input ramp 1..16 on I with h all 1+0j, TAP_COUNT=4. Required: exactly 4 outputs, I = 10, 26, 42, 58. Check 4 pops between consecutive writes.
- Back-pressure: hold out_full=1 for 20 cycles after QUANT. Required: outputs stable, out_wr_en=0, in_rd_en=0 throughout; a single write follows release.
- Saturation and rounding:
  - FRAC_BITS=10, accumulator -1023 gives 0 (truncation toward zero).
  - Accumulator 2^50 gives 0x7FFFFFFF.
- Coefficient gating and reset: a write during MAC is dropped (verify the old h is used); assert reset mid-MAC and check all outputs 0 with no out_wr_en.
